// File: rtl/positdiv_iter_if.sv
// positdiv_iter_if: request/response bundle between a client and the iterative posit divider
interface positdiv_iter_if;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic [31:0] result;
    logic        inf;
    logic        zero;
    logic        done;
    modport master (output start, in1, in2, input busy, result, inf, zero, done);
    modport slave  (input start, in1, in2, output busy, result, inf, zero, done);
endinterface

// File: rtl/positdiv_iter.sv
// positdiv_iter: iterative posit<32,2> divider, restoring fraction division one quotient bit per cycle
module positdiv_iter (
    input  logic           clk,
    input  logic           reset,
    positdiv_iter_if.slave bus
);
    localparam int NBITS  = 32;
    localparam int FBITS  = 27;
    localparam int FHBITS = FBITS + 1;
    localparam int QBITS  = 31;

    typedef enum logic [2:0] {IDLE, DECODE, DIVIDE, NORM, ROUND} state_t;
    typedef struct packed {
        logic             sgn;
        logic [9:0]       scale;
        logic [FBITS-1:0] frac;
    } value_t;

    state_t              r_state, w_next;
    logic [NBITS-1:0]    r_a, r_b, r_result;
    logic                r_sign, r_nar, r_zer, r_sticky, r_inf, r_zero, r_done;
    logic signed [9:0]   r_scale;
    logic [FHBITS-1:0]   r_d;
    logic [FHBITS:0]     r_rem;
    logic [QBITS-1:0]    r_q;
    logic [4:0]          r_cnt;
    value_t              w_va, w_vb;
    logic                w_ge;
    logic [FHBITS:0]     w_diff;
    logic [4:0]          w_sh;
    logic signed [65:0]  w_v;
    logic [NBITS-2:0]    w_body;
    logic [NBITS-1:0]    w_mag, w_sat, w_enc;

    function automatic value_t posit_extract(input logic [NBITS-1:0] p);
        value_t           v;
        logic [NBITS-2:0] x, run, rest;
        logic [5:0]       k;
        logic [7:0]       rk;
        logic [1:0]       e;
        x = p[NBITS-1] ? ~p[NBITS-2:0] + 1'b1 : p[NBITS-2:0];
        run = x[NBITS-2] ? ~x : x;
        k = 6'd31;
        for (int i = 0; i < NBITS-1; i++) if (run[i]) k = 6'(NBITS - 2 - i);
        rest = x << (k + 6'd1);
        rk = x[NBITS-2] ? 8'(k) - 8'd1 : 8'd0 - 8'(k);
        {e, v.frac} = 29'(rest >> 2);
        v.sgn = p[NBITS-1];
        v.scale = {rk, e};
        return v;
    endfunction

    assign w_va = posit_extract(r_a);
    assign w_vb = posit_extract(r_b);
    assign w_ge = r_rem >= {1'b0, r_d};
    assign w_diff = r_rem - {1'b0, r_d};

    // Pack regime/exponent/fraction by arithmetic-shifting a seeded regime pattern, then round and saturate
    always_comb begin
        w_sh = r_scale[6:2] ^ {5{r_scale[9]}};
        w_v = $signed({r_scale[9] ? 2'b01 : 2'b10, r_scale[1:0], r_q[QBITS-2:0], 32'b0}) >>> w_sh;
        w_body = w_v[65:35];
        w_mag = {1'b0, w_body} + {31'b0, w_v[34] & (w_body[0] | (|w_v[33:0]) | r_sticky)};
        w_sat = r_scale > 10'sd120 ? 32'h7FFF_FFFF : r_scale < -10'sd120 ? 32'h0000_0001 : w_mag;
        w_enc = r_sign ? -w_sat : w_sat;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: every operation walks the full sequence, specials included
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.start ? DECODE : IDLE;
            DECODE:  w_next = DIVIDE;
            DIVIDE:  w_next = r_cnt == 5'd0 ? NORM : DIVIDE;
            NORM:    w_next = ROUND;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, decode, restoring divide, normalise, and register the rounded result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_a <= bus.in1;
                    r_b <= bus.in2;
                end
                DECODE: begin
                    r_sign  <= w_va.sgn ^ w_vb.sgn;
                    r_scale <= $signed(w_va.scale) - $signed(w_vb.scale);
                    r_rem   <= {2'b01, w_va.frac};
                    r_d     <= {1'b1, w_vb.frac};
                    r_cnt   <= 5'(QBITS - 1);
                    r_nar   <= r_a == 32'h8000_0000 || r_b == 32'h8000_0000 || r_b == '0;
                    r_zer   <= r_a == '0 && r_b != 32'h8000_0000 && r_b != '0;
                end
                DIVIDE: begin
                    r_rem <= (w_ge ? w_diff : r_rem) << 1;
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                end
                NORM: begin
                    r_sticky <= r_rem != '0;
                    if (!r_q[QBITS-1]) begin
                        r_q     <= r_q << 1;
                        r_scale <= r_scale - 10'sd1;
                    end
                end
                ROUND: begin
                    r_result <= r_nar ? 32'h8000_0000 : r_zer ? 32'h0 : w_enc;
                    r_inf    <= r_nar;
                    r_zero   <= r_zer & ~r_nar;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_state != IDLE;
    assign bus.result = r_result;
    assign bus.inf    = r_inf;
    assign bus.zero   = r_zero;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_positdiv_iter.sv
// tb_positdiv_iter: directed checks of the iterative posit divider
module tb_positdiv_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   lat;
    int   seen;

    positdiv_iter_if bus ();
    positdiv_iter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic div(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic ei, input logic ez);
        int n;
        kick(a, b);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, " lat"}, n, 34);
        check({tag, " res"}, bus.result, exp);
        check({tag, " inf"}, 32'(bus.inf), 32'(ei));
        check({tag, " zero"}, 32'(bus.zero), 32'(ez));
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst result", bus.result, 32'h0);
        check("rst inf", 32'(bus.inf), 32'd0);
        check("rst zero", 32'(bus.zero), 32'd0);
        kick(32'h4000_0000, 32'h4000_0000);
        check("rst wins busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        div("1/1",       32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        div("1/2",       32'h4000_0000, 32'h4800_0000, 32'h3800_0000, 1'b0, 1'b0);
        div("-1/2",      32'hC000_0000, 32'h4800_0000, 32'hC800_0000, 1'b0, 1'b0);
        div("1/3",       32'h4000_0000, 32'h4C00_0000, 32'h32AA_AAAB, 1'b0, 1'b0);
        div("2/1",       32'h4800_0000, 32'h4000_0000, 32'h4800_0000, 1'b0, 1'b0);
        div("-1/-1",     32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 1'b0, 1'b0);
        div("1/-2",      32'h4000_0000, 32'hB800_0000, 32'hC800_0000, 1'b0, 1'b0);
        div("1/0",       32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        div("0/2",       32'h0000_0000, 32'h4800_0000, 32'h0000_0000, 1'b0, 1'b1);
        div("nar/1",     32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0);
        div("1/nar",     32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        div("0/0",       32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        div("max/min",   32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0);
        div("min/max",   32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        div("-max/min",  32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b0);

        kick(32'h4000_0000, 32'h4800_0000);
        repeat (4) @(posedge clk);
        #1;
        kick(32'h4C00_0000, 32'h4000_0000);
        wait_done(lat);
        check("busy start lat", lat + 5, 34);
        check("busy start res", bus.result, 32'h3800_0000);
        kick(32'h4C00_0000, 32'h4000_0000);
        wait_done(lat);
        check("done start lat", lat, 34);
        check("done start res", bus.result, 32'h4C00_0000);

        kick(32'h4000_0000, 32'h4C00_0000);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort result", bus.result, 32'h0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.done === 1'b1) seen++;
        end
        check("abort no done", seen, 0);
        div("after abort", 32'h4000_0000, 32'h4C00_0000, 32'h32AA_AAAB, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
